// File: rtl/sipo.sv
// Serial-in/parallel-out packer: gathers SYM_W-bit symbols MSB-first into WORD_W-bit
// words and hands each finished word to a downstream FIFO through a single holding register.
module sipo #(
    parameter int unsigned SYM_W  = 2,
    parameter int unsigned WORD_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SYM_W-1:0]  data_serial_i,
    input  logic              valid_serial_i,
    output logic              ready_serial_o,
    input  logic              fifo_full_i,
    output logic              fifo_wr_en_o,
    output logic [WORD_W-1:0] fifo_data_o,
    output logic              drop_err_o
);

    localparam int unsigned SYMS  = WORD_W / SYM_W;
    localparam int unsigned CNT_W = (SYMS > 1) ? $clog2(SYMS) : 1;
    localparam logic [CNT_W-1:0] LAST_SYM = CNT_W'(SYMS - 1);

    logic [WORD_W-1:0] shift_reg;
    logic [CNT_W-1:0]  sym_cnt;
    logic [WORD_W-1:0] hold_reg;
    logic              hold_valid;
    logic              drop_err;

    logic              accept;
    logic              word_done;
    logic [WORD_W-1:0] assembled;

    // Stall only when the closing symbol would need a holding register that cannot drain now.
    assign ready_serial_o = !((sym_cnt == LAST_SYM) && hold_valid && fifo_full_i);
    assign fifo_wr_en_o   = hold_valid && !fifo_full_i;
    assign fifo_data_o    = hold_reg;
    assign drop_err_o     = drop_err;

    assign accept    = valid_serial_i && ready_serial_o;
    assign word_done = accept && (sym_cnt == LAST_SYM);
    assign assembled = {shift_reg[WORD_W-SYM_W-1:0], data_serial_i};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg  <= '0;
            sym_cnt    <= '0;
            hold_reg   <= '0;
            hold_valid <= 1'b0;
            drop_err   <= 1'b0;
        end else begin
            if (accept) begin
                shift_reg <= assembled;
                sym_cnt   <= word_done ? '0 : sym_cnt + CNT_W'(1);
            end
            // A word completing on the drain edge reloads the holder instead of emptying it.
            if (word_done) begin
                hold_reg   <= assembled;
                hold_valid <= 1'b1;
            end else if (fifo_wr_en_o) begin
                hold_valid <= 1'b0;
            end
            if (valid_serial_i && !ready_serial_o) begin
                drop_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sipo.sv
// Self-checking bench for sipo: table vectors, directed corner sequences and a random
// phase, all checked against an arithmetic word-level model of the packer.
module tb_sipo;

    localparam int SYMS = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  data_serial_i;
    logic        valid_serial_i;
    logic        ready_serial_o;
    logic        fifo_full_i;
    logic        fifo_wr_en_o;
    logic [15:0] fifo_data_o;
    logic        drop_err_o;

    sipo #(.SYM_W(2), .WORD_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .data_serial_i  (data_serial_i),
        .valid_serial_i (valid_serial_i),
        .ready_serial_o (ready_serial_o),
        .fifo_full_i    (fifo_full_i),
        .fifo_wr_en_o   (fifo_wr_en_o),
        .fifo_data_o    (fifo_data_o),
        .drop_err_o     (drop_err_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: symbol count in the current word, running value, held word.
    int          m_n;
    logic [15:0] m_acc;
    logic [15:0] m_hw;
    bit          m_hv;
    bit          m_drop;
    logic [15:0] exp_q[$];
    bit          use_q;
    int          wr_log[$];

    typedef struct {
        logic [1:0]  sym;
        logic [15:0] exp_word;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_n    = 0;
        m_acc  = '0;
        m_hw   = '0;
        m_hv   = 1'b0;
        m_drop = 1'b0;
        exp_q.delete();
    endtask

    // One clock cycle: drive on the falling edge, check just after, advance the model to the next rising edge.
    task automatic step(input bit v, input logic [1:0] d, input bit f,
                        output bit wr, output bit rdy, output logic [15:0] dat);
        bit e_rdy;
        bit e_wr;
        @(negedge clk);
        valid_serial_i = v;
        data_serial_i  = d;
        fifo_full_i    = f;
        #1;
        e_rdy = !(m_n == SYMS - 1 && m_hv && f);
        e_wr  = m_hv && !f;
        wr  = fifo_wr_en_o;
        rdy = ready_serial_o;
        dat = fifo_data_o;
        chk("ready", 32'(rdy), 32'(e_rdy));
        chk("wr_en", 32'(wr), 32'(e_wr));
        chk("held_word", 32'(dat), 32'(m_hw));
        chk("drop_err", 32'(drop_err_o), 32'(m_drop));
        if (e_wr) begin
            wr_log.push_back(cyc);
            if (use_q) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_write: got write of %0h expected none (cycle %0d)", dat, cyc);
                end else begin
                    chk("written_word", 32'(dat), 32'(exp_q.pop_front()));
                end
            end
            m_hv = 1'b0;
        end
        if (v && e_rdy) begin
            m_acc = 16'((int'(m_acc) * 4 + int'(d)) % 65536);
            if (m_n == SYMS - 1) begin
                m_hw = m_acc;
                m_hv = 1'b1;
                m_n  = 0;
            end else begin
                m_n++;
            end
        end
        if (v && !e_rdy) m_drop = 1'b1;
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b1;
        valid_serial_i = 1'b0;
        fifo_full_i    = 1'b0;
        #1;
        chk("rst_wr_en", 32'(fifo_wr_en_o), 32'd0);
        chk("rst_data", 32'(fifo_data_o), 32'd0);
        chk("rst_drop", 32'(drop_err_o), 32'd0);
        chk("rst_ready", 32'(ready_serial_o), 32'd1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input int maxgap, input bit f, input bit push);
        bit          wr;
        bit          rdy;
        logic [15:0] dat;
        if (push) exp_q.push_back(w);
        for (int k = 0; k < SYMS; k++) begin
            step(1'b1, w[15-2*k -: 2], f, wr, rdy, dat);
            repeat ($urandom_range(maxgap, 0)) step(1'b0, 2'($urandom), f, wr, rdy, dat);
        end
    endtask

    initial begin
        vec_t        tbl[4];
        bit          wr;
        bit          rdy;
        logic [15:0] dat;
        logic [15:0] wa;
        logic [15:0] wb;

        rst            = 1'b1;
        valid_serial_i = 1'b0;
        data_serial_i  = '0;
        fifo_full_i    = 1'b0;
        use_q          = 1'b1;
        model_reset();
        do_reset();

        tbl[0] = '{sym: 2'b10, exp_word: 16'hAAAA};
        tbl[1] = '{sym: 2'b01, exp_word: 16'h5555};
        tbl[2] = '{sym: 2'b11, exp_word: 16'hFFFF};
        tbl[3] = '{sym: 2'b00, exp_word: 16'h0000};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(tbl[i].exp_word);
            for (int k = 0; k < SYMS; k++) step(1'b1, tbl[i].sym, 1'b0, wr, rdy, dat);
            step(1'b0, 2'b00, 1'b0, wr, rdy, dat);
            chk("tbl_wr_pulse", 32'(wr), 32'd1);
            chk("tbl_word", 32'(dat), 32'(tbl[i].exp_word));
            step(1'b0, 2'b00, 1'b0, wr, rdy, dat);
            chk("tbl_single_pulse", 32'(wr), 32'd0);
        end

        // Random words with idle gaps between symbols.
        wr_log.delete();
        for (int i = 0; i < 20; i++) send_word(16'($urandom), 3, 1'b0, 1'b1);
        repeat (3) step(1'b0, 2'b00, 1'b0, wr, rdy, dat);
        chk("gap_writes", 32'(wr_log.size()), 32'd20);
        chk("gap_drained", 32'(exp_q.size()), 32'd0);

        // Back-to-back words: one write every 8 cycles.
        wr_log.delete();
        for (int i = 0; i < 5; i++) send_word(16'($urandom), 0, 1'b0, 1'b1);
        repeat (2) step(1'b0, 2'b00, 1'b0, wr, rdy, dat);
        chk("b2b_writes", 32'(wr_log.size()), 32'd5);
        for (int i = 1; i < wr_log.size(); i++)
            chk("b2b_spacing", 32'(wr_log[i] - wr_log[i-1]), 32'd8);

        // FIFO full for 20 cycles spanning two words.
        wa = 16'($urandom);
        wb = 16'($urandom);
        exp_q.push_back(wa);
        exp_q.push_back(wb);
        for (int k = 0; k < SYMS; k++) step(1'b1, wa[15-2*k -: 2], 1'b1, wr, rdy, dat);
        for (int k = 0; k < SYMS - 1; k++) step(1'b1, wb[15-2*k -: 2], 1'b1, wr, rdy, dat);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, wb[1:0], 1'b1, wr, rdy, dat);
            chk("stall_ready", 32'(rdy), 32'd0);
            chk("stall_no_write", 32'(wr), 32'd0);
        end
        chk("stall_drop_err", 32'(drop_err_o), 32'd1);
        step(1'b1, wb[1:0], 1'b0, wr, rdy, dat);
        chk("release_ready", 32'(rdy), 32'd1);
        chk("release_wr", 32'(wr), 32'd1);
        chk("release_word_a", 32'(dat), 32'(wa));
        step(1'b0, 2'b00, 1'b0, wr, rdy, dat);
        chk("second_wr", 32'(wr), 32'd1);
        chk("second_word_b", 32'(dat), 32'(wb));
        step(1'b0, 2'b00, 1'b0, wr, rdy, dat);
        chk("stall_drained", 32'(exp_q.size()), 32'd0);

        // Reset with a held word and a partial word in flight.
        send_word(16'hBEEF, 0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b1, 2'($urandom), 1'b1, wr, rdy, dat);
        do_reset();
        wr_log.delete();
        send_word(16'h1234, 0, 1'b0, 1'b1);
        repeat (3) step(1'b0, 2'b00, 1'b0, wr, rdy, dat);
        chk("post_rst_writes", 32'(wr_log.size()), 32'd1);
        chk("post_rst_drained", 32'(exp_q.size()), 32'd0);

        // Free-running random traffic and backpressure.
        use_q = 1'b0;
        for (int i = 0; i < 800; i++)
            step($urandom_range(9, 0) < 7, 2'($urandom), $urandom_range(3, 0) == 0, wr, rdy, dat);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
